// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/response, redirect and decode side.
interface instr_fetch_queue_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dec_valid;
  logic [31:0]       dec_instr;
  logic [ADDR_W-1:0] dec_pc;
  logic              dec_ready;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );

  // Memory / core side
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with credit-limited issue, prefetch FIFO,
// and redirect flush that drains stale in-flight responses.
module instr_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [PW-1:0]     wr_q, rd_q;
  logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
  logic [31:0]       ins_mem_q [DEPTH];

  logic              redir, credit_ok, req_valid, accept, rsp, drop, push, pop;
  logic [ADDR_W-1:0] redir_pc;

  // Handshake qualifiers; a redirect outranks every other event this cycle
  always_comb begin
    redir     = bus.redirect_valid && (state_q != BOOT);
    redir_pc  = bus.redirect_pc & ~ADDR_W'(3);
    credit_ok = ({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH_W;
    req_valid = (state_q == RUN) && !bus.redirect_valid && credit_ok;
    accept    = req_valid && bus.imem_req_ready;
    rsp       = bus.imem_rsp_valid;
    drop      = (disc_q != '0);
    push      = rsp && !drop && !redir;
    pop       = (cnt_q != '0) && bus.dec_ready && !redir;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = (cnt_q != '0);
  assign bus.dec_instr      = ins_mem_q[rd_q];
  assign bus.dec_pc         = pc_mem_q[rd_q];

  // Next-state for PCs, credit counters and the fetch FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = accept ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d   = push ? rsp_pc_q + STEP : rsp_pc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    out_d      = out_q + CW'(accept) - CW'(rsp);
    disc_d     = (rsp && drop) ? disc_q - CW'(1) : disc_q;
    if (redir) begin
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      cnt_d      = '0;
      // Everything still in flight is stale; a same-cycle response is already gone
      disc_d     = out_q - CW'(rsp);
      out_d      = out_q - CW'(rsp);
    end
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redir) state_d = (disc_d != '0) ? DRAIN : RUN;
      DRAIN:   if (redir) state_d = (disc_d != '0) ? DRAIN : RUN;
               else if (disc_d == '0) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      cnt_q      <= '0;
      out_q      <= '0;
      disc_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      if (redir) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PW'(1);
        if (pop)  rd_q <= rd_q + PW'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_q]  <= rsp_pc_q;
      ins_mem_q[wr_q] <= bus.imem_rsp_data;
    end
  end

  // Credit rule must keep the FIFO from overflowing
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && cnt_q == CW'(DEPTH)));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench: memory model with configurable latency, scoreboard of expected
// {pc, instr} pairs, table of redirect scenarios plus directed sequences.
module tb_instr_fetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.ADDR_W(32)) bus();
  instr_fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { int lat; int pre; bit sync_rsp; logic [31:0] rpc; logic [31:0] exp_pc; } vec_t;

  mreq_t       pend[$];
  logic [31:0] exp_q[$];
  int checks = 0, passed = 0;
  int cyc = 0, lat = 1, n_req = 0, n_dec = 0, stale_left = 0;
  logic [31:0] nxt_addr = '0, first_req, first_dec;
  bit watch_req = 0, watch_dec = 0;
  logic s_req_valid, s_dec_valid;
  logic [31:0] s_req_addr, s_dec_pc, s_dec_instr;
  vec_t vecs[5];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: drive memory response, observe at +1, advance to next negedge
  task automatic tick();
    mreq_t p;
    logic [31:0] e;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = p.addr ^ K;
      if (stale_left > 0) stale_left--;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    s_req_valid = bus.imem_req_valid; s_req_addr = bus.imem_req_addr;
    s_dec_valid = bus.dec_valid; s_dec_pc = bus.dec_pc; s_dec_instr = bus.dec_instr;
    if (!reset) begin
      if (bus.redirect_valid) begin
        chk("redir_req_gated", {31'd0, s_req_valid}, 32'd0);
        exp_q.delete();
        nxt_addr   = {bus.redirect_pc[31:2], 2'b00};
        stale_left = pend.size();
        watch_req  = 1; watch_dec = 1;
      end else begin
        if (s_req_valid && bus.imem_req_ready) begin
          if (watch_req) begin
            chk("drain_before_issue", stale_left, 0);
            first_req = s_req_addr; watch_req = 0;
          end
          chk("req_addr", s_req_addr, nxt_addr);
          pend.push_back('{addr: s_req_addr, due: cyc + lat});
          exp_q.push_back(nxt_addr);
          nxt_addr += 32'd4;
          n_req++;
        end
        if (s_dec_valid && bus.dec_ready) begin
          if (watch_dec) begin first_dec = s_dec_pc; watch_dec = 0; end
          n_dec++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL dec_unexpected: pc %h delivered, nothing expected (cycle %0d)", s_dec_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("dec_pc", s_dec_pc, e);
            chk("dec_instr", s_dec_instr, e ^ K);
          end
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    pend.delete(); exp_q.delete();
    nxt_addr = '0; stale_left = 0; n_req = 0; n_dec = 0; watch_req = 0; watch_dec = 0;
    @(negedge clk);
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
    chk("rst_dec_pc", bus.dec_pc, 32'd0);
    chk("rst_dec_instr", bus.dec_instr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int gaps, t;
    logic [31:0] a0;
    vecs[0] = '{lat: 3, pre: 12, sync_rsp: 1'b0, rpc: 32'h0000_0100, exp_pc: 32'h0000_0100};
    vecs[1] = '{lat: 1, pre: 8,  sync_rsp: 1'b1, rpc: 32'h0000_0103, exp_pc: 32'h0000_0100};
    vecs[2] = '{lat: 2, pre: 8,  sync_rsp: 1'b1, rpc: 32'hFFFF_FFF8, exp_pc: 32'hFFFF_FFF8};
    vecs[3] = '{lat: 3, pre: 9,  sync_rsp: 1'b1, rpc: 32'h0000_2006, exp_pc: 32'h0000_2004};
    vecs[4] = '{lat: 1, pre: 5,  sync_rsp: 1'b0, rpc: 32'h0000_0040, exp_pc: 32'h0000_0040};

    bus.imem_req_ready = 1'b1; bus.dec_ready = 1'b1; bus.redirect_pc = '0;
    reset = 1'b1;
    @(negedge clk);

    // Start-up latency and continuous stream with a 1-cycle memory
    lat = 1;
    do_reset();
    tick(); chk("boot_no_req", {31'd0, s_req_valid}, 32'd0);
    tick(); chk("first_req_valid", {31'd0, s_req_valid}, 32'd1);
            chk("first_req_addr", s_req_addr, 32'd0);
    tick(); chk("no_bypass", {31'd0, s_dec_valid}, 32'd0);
    tick(); chk("first_dec_valid", {31'd0, s_dec_valid}, 32'd1);
            chk("first_dec_pc", s_dec_pc, 32'd0);
    gaps = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (!s_dec_valid) gaps++; end
    chk("no_gaps", gaps, 0);

    // Request held stable while memory stalls
    bus.imem_req_ready = 1'b0;
    tick(); a0 = s_req_addr;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", {31'd0, s_req_valid}, 32'd1);
      chk("stall_addr", s_req_addr, a0);
    end
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // Decode backpressure: exactly DEPTH requests, then hold
    do_reset();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("bp_req_count", n_req, 4);
    chk("bp_req_blocked", {31'd0, s_req_valid}, 32'd0);
    chk("bp_head_pc", s_dec_pc, 32'd0);
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("bp_delivered", {31'd0, n_dec >= 12}, 32'd1);

    // Redirect scenarios
    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      bus.dec_ready = 1'b1;
      for (int i = 0; i < vecs[v].pre; i++) tick();
      if (vecs[v].sync_rsp) begin
        t = 0;
        while (!(pend.size() > 0 && pend[0].due <= cyc) && t < 10) begin tick(); t++; end
        chk("sync_rsp_found", {31'd0, t < 10}, 32'd1);
      end
      bus.redirect_valid = 1'b1; bus.redirect_pc = vecs[v].rpc;
      tick();
      bus.redirect_valid = 1'b0;
      tick(); chk("flush_empty", {31'd0, s_dec_valid}, 32'd0);
      t = 0;
      while ((watch_req || watch_dec) && t < 40) begin tick(); t++; end
      chk("redir_timeout", {31'd0, t < 40}, 32'd1);
      chk("redir_first_req", first_req, vecs[v].exp_pc);
      chk("redir_first_dec", first_dec, vecs[v].exp_pc);
      for (int i = 0; i < 6; i++) tick();
    end

    // Reset mid-stream with requests outstanding and FIFO occupied
    lat = 3; bus.dec_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_fifo_busy", {31'd0, s_dec_valid}, 32'd1);
    do_reset();
    tick(); chk("mid_boot_no_req", {31'd0, s_req_valid}, 32'd0);
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("mid_restart", {31'd0, n_dec > 0}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
